// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multi-cycle sequencer and the MIPS datapath.
interface multicycle_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    localparam int unsigned OP_W  = 6;
    localparam int unsigned SEL_W = 3;
    localparam int unsigned DST_W = 2;

    // Instruction fields and datapath status
    logic [OP_W-1:0]  opcode;
    logic [OP_W-1:0]  funct;
    logic             zero;
    logic             gtz;
    logic             mem_ready;

    // Strobes
    logic             ir_write;
    logic             pc_write;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;

    // Decoded control fields
    logic [SEL_W-1:0] alu_control;
    logic             alu_src;
    logic [SEL_W-1:0] ext_control;
    logic [DST_W-1:0] reg_dst;
    logic [SEL_W-1:0] mem2reg;
    logic [SEL_W-1:0] npc_control;

    // Sequencer status
    logic [SEL_W-1:0] state;
    logic             instr_done;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, funct, zero, gtz, mem_ready,
        output ir_write, pc_write, reg_write, mem_read, mem_write,
        output alu_control, alu_src, ext_control, reg_dst, mem2reg, npc_control,
        output state, instr_done, retired
    );

    modport slave (
        output opcode, funct, zero, gtz, mem_ready,
        input  ir_write, pc_write, reg_write, mem_read, mem_write,
        input  alu_control, alu_src, ext_control, reg_dst, mem2reg, npc_control,
        input  state, instr_done, retired
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB with a data-memory
// ready handshake and a retired-instruction counter. Decode fields are purely
// combinational from opcode/funct; strobes follow the current state and are
// held low while reset is asserted so an aborted instruction never writes.
module multicycle_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    multicycle_ctrl_if.master bus
);
    localparam int unsigned SEL_W = 3;
    localparam int unsigned DST_W = 2;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    typedef enum logic [4:0] {
        I_ADD, I_SUB, I_XOR, I_SLL, I_JR, I_JALR,
        I_ORI, I_ADDI, I_LUI, I_LW, I_LB, I_SW,
        I_BEQ, I_BGTZ, I_J, I_JAL, I_BAD
    } instr_t;

    state_t           state, state_next;
    instr_t           instr;
    logic [CNT_W-1:0] retired;

    logic             ir_write, pc_write, reg_write, mem_read, mem_write, instr_done;
    logic [SEL_W-1:0] alu_control, ext_control, mem2reg, npc_control;
    logic [DST_W-1:0] reg_dst;
    logic             alu_src;

    // Classify the instruction from opcode/funct
    always_comb begin
        instr = I_BAD;
        case (bus.opcode)
            6'h00: begin
                case (bus.funct)
                    6'h20:   instr = I_ADD;
                    6'h22:   instr = I_SUB;
                    6'h26:   instr = I_XOR;
                    6'h00:   instr = I_SLL;
                    6'h08:   instr = I_JR;
                    6'h09:   instr = I_JALR;
                    default: instr = I_BAD;
                endcase
            end
            6'h0D:   instr = I_ORI;
            6'h08:   instr = I_ADDI;
            6'h0F:   instr = I_LUI;
            6'h23:   instr = I_LW;
            6'h20:   instr = I_LB;
            6'h2B:   instr = I_SW;
            6'h04:   instr = I_BEQ;
            6'h07:   instr = I_BGTZ;
            6'h02:   instr = I_J;
            6'h03:   instr = I_JAL;
            default: instr = I_BAD;
        endcase
    end

    // Datapath steering fields, valid in every state
    always_comb begin
        alu_control = 3'b000;
        alu_src     = 1'b0;
        ext_control = 3'b000;
        reg_dst     = 2'b00;
        mem2reg     = 3'b000;
        npc_control = 3'b000;
        case (instr)
            I_ADD:  reg_dst = 2'b01;
            I_SUB:  begin alu_control = 3'b001; reg_dst = 2'b01; end
            I_XOR:  begin alu_control = 3'b010; reg_dst = 2'b01; end
            I_SLL:  begin alu_control = 3'b100; reg_dst = 2'b01; end
            I_JR:   npc_control = 3'b100;
            I_JALR: begin reg_dst = 2'b01; mem2reg = 3'b011; npc_control = 3'b100; end
            I_ORI:  begin alu_control = 3'b011; alu_src = 1'b1; end
            I_ADDI: begin alu_src = 1'b1; ext_control = 3'b001; end
            I_LUI:  begin alu_src = 1'b1; ext_control = 3'b010; mem2reg = 3'b010; end
            I_LW:   begin alu_src = 1'b1; ext_control = 3'b001; mem2reg = 3'b001; end
            I_LB:   begin alu_src = 1'b1; ext_control = 3'b001; mem2reg = 3'b100; end
            I_SW:   begin alu_src = 1'b1; ext_control = 3'b001; end
            I_BEQ:  begin
                alu_control = 3'b001;
                ext_control = 3'b001;
                npc_control = bus.zero ? 3'b001 : 3'b000;
            end
            I_BGTZ: begin
                ext_control = 3'b001;
                npc_control = bus.gtz ? 3'b001 : 3'b000;
            end
            I_J:    npc_control = 3'b010;
            I_JAL:  begin reg_dst = 2'b10; mem2reg = 3'b011; npc_control = 3'b010; end
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    // Next state and per-state strobes; reset masks every strobe
    always_comb begin
        state_next = state;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        instr_done = 1'b0;
        case (state)
            FETCH: begin
                ir_write   = 1'b1;
                state_next = DECODE;
            end
            DECODE: begin
                if (instr == I_BAD) begin
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                    state_next = FETCH;
                end else begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                case (instr)
                    I_LW, I_LB, I_SW: state_next = MEM;
                    I_BEQ, I_BGTZ, I_J, I_JR, I_BAD: begin
                        pc_write   = 1'b1;
                        instr_done = 1'b1;
                        state_next = FETCH;
                    end
                    default: state_next = WB;
                endcase
            end
            MEM: begin
                mem_read  = (instr == I_LW) || (instr == I_LB);
                mem_write = (instr == I_SW);
                if (bus.mem_ready) begin
                    if (instr == I_SW) begin
                        pc_write   = 1'b1;
                        instr_done = 1'b1;
                        state_next = FETCH;
                    end else begin
                        state_next = WB;
                    end
                end
            end
            WB: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                instr_done = 1'b1;
                state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase
        if (reset) begin
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            reg_write  = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            instr_done = 1'b0;
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset)           retired <= '0;
        else if (instr_done) retired <= retired + CNT_W'(1);
    end

    assign bus.ir_write    = ir_write;
    assign bus.pc_write    = pc_write;
    assign bus.reg_write   = reg_write;
    assign bus.mem_read    = mem_read;
    assign bus.mem_write   = mem_write;
    assign bus.instr_done  = instr_done;
    assign bus.alu_control = alu_control;
    assign bus.alu_src     = alu_src;
    assign bus.ext_control = ext_control;
    assign bus.reg_dst     = reg_dst;
    assign bus.mem2reg     = mem2reg;
    assign bus.npc_control = npc_control;
    assign bus.state       = SEL_W'(state);
    assign bus.retired     = retired;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by
// cycle and compares state, strobes and decode fields with hand-derived values.
module tb_multicycle_ctrl;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    multicycle_ctrl_if #(.CNT_W(32)) bus ();

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it if it mismatches
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock, then settle away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare state and all strobes for the current cycle
    task automatic cyc(input string tag, input logic [2:0] st, input logic irw, input logic pcw,
                       input logic rw, input logic mr, input logic mw, input logic dn);
        check({tag, ".state"},      32'(bus.state),      32'(st));
        check({tag, ".ir_write"},   32'(bus.ir_write),   32'(irw));
        check({tag, ".pc_write"},   32'(bus.pc_write),   32'(pcw));
        check({tag, ".reg_write"},  32'(bus.reg_write),  32'(rw));
        check({tag, ".mem_read"},   32'(bus.mem_read),   32'(mr));
        check({tag, ".mem_write"},  32'(bus.mem_write),  32'(mw));
        check({tag, ".instr_done"}, 32'(bus.instr_done), 32'(dn));
    endtask

    task automatic load(input logic [5:0] op, input logic [5:0] fn);
        bus.opcode = op;
        bus.funct  = fn;
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b1;
        bus.zero      = 1'b0;
        bus.gtz       = 1'b0;
        bus.mem_ready = 1'b0;
        load(6'h00, 6'h20);

        // 1: reset held for 3 cycles, then add
        for (int i = 0; i < 3; i++) begin
            tick();
            cyc("rst", 3'd0, 0, 0, 0, 0, 0, 0);
            check("rst.retired", bus.retired, 32'd0);
        end
        reset = 1'b0;
        #1;
        cyc("add.F", 3'd0, 1, 0, 0, 0, 0, 0);
        tick(); cyc("add.D", 3'd1, 0, 0, 0, 0, 0, 0);
        tick(); cyc("add.E", 3'd2, 0, 0, 0, 0, 0, 0);
        tick(); cyc("add.W", 3'd4, 0, 1, 1, 0, 0, 1);
        check("add.reg_dst", 32'(bus.reg_dst), 32'd1);
        check("add.npc", 32'(bus.npc_control), 32'd0);
        check("add.alu", 32'(bus.alu_control), 32'd0);
        tick(); cyc("add.end", 3'd0, 1, 0, 0, 0, 0, 0);
        check("add.retired", bus.retired, 32'd1);

        // 2: lw with two wait cycles
        load(6'h23, 6'h00);
        #1;
        cyc("lw.F", 3'd0, 1, 0, 0, 0, 0, 0);
        tick(); cyc("lw.D", 3'd1, 0, 0, 0, 0, 0, 0);
        tick(); cyc("lw.E", 3'd2, 0, 0, 0, 0, 0, 0);
        tick(); cyc("lw.M1", 3'd3, 0, 0, 0, 1, 0, 0);
        tick(); cyc("lw.M2", 3'd3, 0, 0, 0, 1, 0, 0);
        tick(); bus.mem_ready = 1'b1; #1;
        cyc("lw.M3", 3'd3, 0, 0, 0, 1, 0, 0);
        tick(); bus.mem_ready = 1'b0; #1;
        cyc("lw.W", 3'd4, 0, 1, 1, 0, 0, 1);
        check("lw.mem2reg", 32'(bus.mem2reg), 32'd1);
        check("lw.ext", 32'(bus.ext_control), 32'd1);
        check("lw.reg_dst", 32'(bus.reg_dst), 32'd0);
        check("lw.alu_src", 32'(bus.alu_src), 32'd1);
        tick(); cyc("lw.end", 3'd0, 1, 0, 0, 0, 0, 0);
        check("lw.retired", bus.retired, 32'd2);

        // 3: beq taken, then not taken
        load(6'h04, 6'h00);
        bus.zero = 1'b1;
        #1;
        tick(); cyc("beq1.D", 3'd1, 0, 0, 0, 0, 0, 0);
        tick(); cyc("beq1.E", 3'd2, 0, 1, 0, 0, 0, 1);
        check("beq1.npc", 32'(bus.npc_control), 32'd1);
        tick(); bus.zero = 1'b0; #1;
        cyc("beq2.F", 3'd0, 1, 0, 0, 0, 0, 0);
        tick(); cyc("beq2.D", 3'd1, 0, 0, 0, 0, 0, 0);
        tick(); cyc("beq2.E", 3'd2, 0, 1, 0, 0, 0, 1);
        check("beq2.npc", 32'(bus.npc_control), 32'd0);
        tick();
        check("beq.retired", bus.retired, 32'd4);

        // bgtz taken
        load(6'h07, 6'h00);
        bus.gtz = 1'b1;
        tick(); tick(); cyc("bgtz.E", 3'd2, 0, 1, 0, 0, 0, 1);
        check("bgtz.npc", 32'(bus.npc_control), 32'd1);
        bus.gtz = 1'b0;
        #1;
        check("bgtz.npc_nt", 32'(bus.npc_control), 32'd0);
        tick();

        // 4: jal then jalr
        load(6'h03, 6'h00);
        tick(); tick(); tick();
        cyc("jal.W", 3'd4, 0, 1, 1, 0, 0, 1);
        check("jal.reg_dst", 32'(bus.reg_dst), 32'd2);
        check("jal.mem2reg", 32'(bus.mem2reg), 32'd3);
        check("jal.npc", 32'(bus.npc_control), 32'd2);
        tick();
        load(6'h00, 6'h09);
        tick(); tick(); tick();
        cyc("jalr.W", 3'd4, 0, 1, 1, 0, 0, 1);
        check("jalr.reg_dst", 32'(bus.reg_dst), 32'd1);
        check("jalr.mem2reg", 32'(bus.mem2reg), 32'd3);
        check("jalr.npc", 32'(bus.npc_control), 32'd4);
        tick();
        check("jalr.retired", bus.retired, 32'd7);

        // ori decode fields while in FETCH
        load(6'h0D, 6'h00);
        #1;
        check("ori.alu", 32'(bus.alu_control), 32'd3);
        check("ori.alu_src", 32'(bus.alu_src), 32'd1);
        check("ori.ext", 32'(bus.ext_control), 32'd0);
        load(6'h0F, 6'h00);
        #1;
        check("lui.ext", 32'(bus.ext_control), 32'd2);
        check("lui.mem2reg", 32'(bus.mem2reg), 32'd2);

        // 5: sw aborted by reset in its second MEM cycle
        load(6'h2B, 6'h00);
        tick(); tick(); tick();
        cyc("sw.M1", 3'd3, 0, 0, 0, 0, 1, 0);
        tick();
        cyc("sw.M2", 3'd3, 0, 0, 0, 0, 1, 0);
        reset = 1'b1;
        #1;
        cyc("sw.rst", 3'd0, 0, 0, 0, 0, 0, 0);
        check("sw.retired", bus.retired, 32'd0);
        bus.mem_ready = 1'b1;
        tick(); cyc("sw.rst2", 3'd0, 0, 0, 0, 0, 0, 0);
        bus.mem_ready = 1'b0;
        reset = 1'b0;

        // 6: unknown opcode is a two-cycle nop
        load(6'h3F, 6'h00);
        #1;
        cyc("bad.F", 3'd0, 1, 0, 0, 0, 0, 0);
        tick(); cyc("bad.D", 3'd1, 0, 1, 0, 0, 0, 1);
        check("bad.npc", 32'(bus.npc_control), 32'd0);
        tick(); cyc("bad.end", 3'd0, 1, 0, 0, 0, 0, 0);
        check("bad.retired", bus.retired, 32'd1);

        // unknown R-type funct behaves the same
        load(6'h00, 6'h3F);
        tick(); cyc("badr.D", 3'd1, 0, 1, 0, 0, 0, 1);
        tick();

        // j: three cycles, npc jump
        load(6'h02, 6'h00);
        tick(); tick(); cyc("j.E", 3'd2, 0, 1, 0, 0, 0, 1);
        check("j.npc", 32'(bus.npc_control), 32'd2);
        tick();
        check("j.retired", bus.retired, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the MIPS datapath. It replaces single-cycle decode with a FETCH/DECODE/EXEC/MEM/WB state machine.
- Control fields (ALU op, extender mode, register destination, writeback source, next-PC source) are decoded from opcode/funct in every state. Read/write/PC strobes are issued only in the owning state.
- Data memory has a ready handshake, so MEM may stretch over several cycles.
- The block also keeps a retired-instruction counter.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- opcode  input  6  IR[31:26]; stable from DECODE until instruction end.
- funct  input  6  IR[5:0].
- zero  input  1  rs==rt, from the comparator.
- gtz  input  1  signed rs>0.
- mem_ready  input  1  data memory has completed the current access.
- ir_write  output  1  latch the fetched instruction.
- pc_write  output  1  load PC with the NPC selected by npc_control.
- reg_write  output  1  GRF write enable.
- mem_read  output  1  data memory read strobe.
- mem_write  output  1  data memory write strobe.
- alu_control  output  3  000 add, 001 sub, 010 xor, 011 or, 100 sll.
- alu_src  output  1  0 = rt, 1 = extended immediate.
- ext_control  output  3  000 zero-extend, 001 sign-extend, 010 lui shift.
- reg_dst  output  2  00 rt, 01 rd, 10 $31.
- mem2reg  output  3  000 ALU result, 001 word, 010 lui immediate, 011 PC+4, 100 byte.
- npc_control  output  3  000 PC+4, 001 branch, 010 jump, 100 register.
- state  output  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- instr_done  output  1  one-cycle pulse in the final cycle of each instruction.
- retired  output  CNT_W  count of completed instructions.

Behaviour:
- Supported instructions: add, sub, xor, sll, jr, jalr (R-type), ori, addi, lui, lw, lb, sw, beq, bgtz, j, jal.
- Reset:
  - While reset is high: state=FETCH, retired=0, and all strobes (ir_write, pc_write, reg_write, mem_read, mem_write, instr_done) are forced to 0.
  - Reset asserted mid-instruction, including a MEM wait, aborts the instruction immediately with no write.
- Decode fields are combinational from opcode/funct in every state.
  - ext_control = 001 for lw, lb, sw, beq, bgtz, addi; 010 for lui; 000 otherwise.
  - alu_src = 1 for ori, lw, lb, sw, lui, addi.
- FETCH: ir_write=1, then go to DECODE.
- DECODE:
  - Known opcode: go to EXEC.
  - Unknown opcode or funct: treated as a nop. pc_write=1, npc 000, instr_done=1, go to FETCH.
- EXEC, by instruction:
  - add, sub, xor, sll, ori, addi, lui, jal, jalr: go to WB.
  - lw, lb, sw: go to MEM.
  - beq: pc_write=1, npc=001 if zero else 000, instr_done=1, go to FETCH.
  - bgtz: same as beq, but taken when gtz.
  - j: pc_write=1, npc 010, instr_done=1, go to FETCH.
  - jr: pc_write=1, npc 100, instr_done=1, go to FETCH.
- MEM:
  - mem_read (lw/lb) or mem_write (sw) is held high every cycle until mem_ready=1 is sampled.
  - While mem_ready=0: stay in MEM.
  - On mem_ready=1 for lw/lb: go to WB.
  - On mem_ready=1 for sw: pc_write=1, instr_done=1, go to FETCH.
- WB:
  - reg_write=1, pc_write=1, instr_done=1, go to FETCH.
  - npc is 010 for jal, 100 for jalr, 000 otherwise.
  - PC+4 for the link value comes from the old PC, which is still valid because the PC loads at the end of this cycle.
- retired increments on every clock edge where instr_done=1, and wraps from all-ones to 0.
- Latency in cycles: ALU/lui/jal/jalr 4; lw/lb 5+waits; sw 4+waits; branch, j, jr 3; unknown 2.
- opcode/funct changing outside the DECODE–end window has no effect on strobes.

Test Plan:
1. Reset high for 3 cycles, then release, with IR=add (opcode 0, funct 0x20) → strobes stay low during reset. After release, state sequence is 0,1,2,4,0. In cycle 4: reg_write=1, reg_dst=01, pc_write=1, npc=000. retired=1.
2. lw, with mem_ready low for 2 MEM cycles then high → states 0,1,2,3,3,3,4. mem_read=1 in all three MEM cycles. WB has mem2reg=001, ext_control=001. Total 7 cycles.
3. beq with zero=1, then beq with zero=0 → each takes 3 cycles. EXEC pc_write=1 with npc=001, then npc=000. reg_write stays 0. retired increases by 2.
4. jal, then jalr (funct 0x09) → WB has reg_dst=10, mem2reg=011, npc=010 for jal; reg_dst=01, npc=100 for jalr.
5. sw with reset asserted during its second MEM cycle → mem_write drops to 0 immediately; state=0; retired=0; no pc_write pulse.
6. Opcode 0x3F → FETCH, DECODE only. DECODE has pc_write=1, npc=000, instr_done=1, and no reg_write/mem strobe.
